// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: branch redirect with fixed squash window,
// circular return-address stack, and sticky halt.
module pc_sequencer #(
  parameter int          FLUSH_DEPTH = 2,
  parameter int          RAS_DEPTH   = 4,
  parameter logic [11:0] RESET_PC    = 12'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_target,
  input  logic        call,
  input  logic        ret,
  input  logic        halt,
  output logic [11:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        ras_empty,
  output logic        ras_full,
  output logic [1:0]  state
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state_r;
  logic [11:0]     pc_r;
  logic [2:0]      cnt_r;
  logic [PW-1:0]   ptr_r;
  logic [CW-1:0]   count_r;
  logic [11:0]     stack_r [RAS_DEPTH];

  logic [11:0]     pc_inc_s;
  logic [PW-1:0]   top_s;
  logic            ras_empty_s;
  logic            ras_full_s;
  logic            push_s;
  logic            pop_s;

  assign pc_inc_s    = pc_r + 12'd1;
  assign top_s       = ptr_r - PW'(1);
  assign ras_empty_s = (count_r == CW'(0));
  assign ras_full_s  = (count_r == CW'(RAS_DEPTH));

  // Stack operations only happen in an unstalled RUN cycle with no redirect or halt.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (state_r == RUN && !redirect_valid && !halt && !stall) begin
      if (ret) begin
        pop_s = !ras_empty_s;
      end else begin
        push_s = call;
      end
    end else begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      stack_r[ptr_r] <= pc_inc_s;
    end
  end

  // Sequencer FSM, PC register and stack bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
      cnt_r   <= 3'd0;
      ptr_r   <= '0;
      count_r <= '0;
    end else begin
      case (state_r)
        RUN: begin
          if (redirect_valid) begin
            pc_r    <= redirect_target;
            state_r <= FLUSH;
            cnt_r   <= 3'(FLUSH_DEPTH - 1);
          end else if (halt) begin
            state_r <= HALT;
          end else if (pop_s) begin
            pc_r    <= stack_r[top_s];
            ptr_r   <= top_s;
            count_r <= count_r - CW'(1);
          end else if (push_s) begin
            pc_r  <= pc_inc_s;
            ptr_r <= ptr_r + PW'(1);
            // When full the write above overwrites the oldest entry.
            if (!ras_full_s) begin
              count_r <= count_r + CW'(1);
            end
          end else if (!stall) begin
            pc_r <= pc_inc_s;
          end
        end
        FLUSH: begin
          if (redirect_valid) begin
            pc_r  <= redirect_target;
            cnt_r <= 3'(FLUSH_DEPTH - 1);
          end else if (cnt_r == 3'd0) begin
            state_r <= RUN;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign pc          = pc_r;
  assign state       = state_r;
  assign fetch_valid = (state_r == RUN);
  assign flush       = (state_r == FLUSH);
  assign ras_empty   = ras_empty_s;
  assign ras_full    = ras_full_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected outputs are queued per step and
// compared after the clock edge (or immediately for async reset).
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [11:0] redirect_target;
  logic        call;
  logic        ret;
  logic        halt;
  logic [11:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        ras_empty;
  logic        ras_full;
  logic [1:0]  state;

  pc_sequencer #(.FLUSH_DEPTH(2), .RAS_DEPTH(4), .RESET_PC(12'd0)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call            (call),
    .ret             (ret),
    .halt            (halt),
    .pc              (pc),
    .fetch_valid     (fetch_valid),
    .flush           (flush),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .state           (state)
  );

  localparam logic [1:0] S_RUN = 2'd0, S_FLUSH = 2'd1, S_HALT = 2'd2;

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc, fetch_valid, flush, ras_empty, ras_full, state}
  function automatic logic [17:0] pack(input logic [11:0] p, input logic [1:0] st,
                                       input logic re, input logic rf);
    return {p, (st == S_RUN), (st == S_FLUSH), re, rf, st};
  endfunction

  task automatic expect_out(input string tag, input logic [11:0] p, input logic [1:0] st,
                            input logic re, input logic rf);
    exp_t e;
    e.tag = tag;
    e.v   = pack(p, st, re, rf);
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [17:0] obs;
    e   = exp_q.pop_front();
    obs = {pc, fetch_valid, flush, ras_empty, ras_full, state};
    vectors++;
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s: observed pc=%h fv=%b fl=%b re=%b rf=%b st=%0d, expected pc=%h fv=%b fl=%b re=%b rf=%b st=%0d",
             e.tag, obs[17:6], obs[5], obs[4], obs[3], obs[2], obs[1:0],
             e.v[17:6], e.v[5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
    end
  endtask

  // One clock step: drive inputs, queue the expected post-edge outputs, compare after the edge.
  task automatic step(input string tag, input logic s, input logic rv, input logic [11:0] tgt,
                      input logic c, input logic r, input logic h,
                      input logic [11:0] p, input logic [1:0] st, input logic re, input logic rf);
    stall = s; redirect_valid = rv; redirect_target = tgt; call = c; ret = r; halt = h;
    expect_out(tag, p, st, re, rf);
    @(posedge clock);
    #1;
    check_out();
    stall = 1'b0; redirect_valid = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0;
  endtask

  task automatic idle(input string tag, input logic [11:0] p, input logic [1:0] st,
                      input logic re, input logic rf);
    step(tag, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, p, st, re, rf);
  endtask

  task automatic redirect_to(input string tag, input logic [11:0] tgt, input logic re, input logic rf);
    step({tag, "_redir"}, 1'b0, 1'b1, tgt, 1'b0, 1'b0, 1'b0, tgt, S_FLUSH, re, rf);
    idle({tag, "_flush2"}, tgt, S_FLUSH, re, rf);
    idle({tag, "_resume"}, tgt, S_RUN, re, rf);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 12'h000;
    call = 1'b0; ret = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset", 12'h000, S_RUN, 1'b1, 1'b0);
    check_out();
    reset = 1'b0;

    // Free run 1..10
    for (int i = 1; i <= 10; i++) begin
      idle($sformatf("run_%0d", i), 12'(i), S_RUN, 1'b1, 1'b0);
    end

    // Redirect at pc=10 to 0x200
    step("redir_200", 1'b0, 1'b1, 12'h200, 1'b0, 1'b0, 1'b0, 12'h200, S_FLUSH, 1'b1, 1'b0);
    idle("flush_200_b", 12'h200, S_FLUSH, 1'b1, 1'b0);
    idle("resume_200", 12'h200, S_RUN, 1'b1, 1'b0);
    idle("run_201", 12'h201, S_RUN, 1'b1, 1'b0);
    idle("run_202", 12'h202, S_RUN, 1'b1, 1'b0);

    // Call at 0x050, redirect to 0x300, then return
    redirect_to("to_050", 12'h050, 1'b1, 1'b0);
    step("call_050", 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h051, S_RUN, 1'b0, 1'b0);
    step("redir_300", 1'b0, 1'b1, 12'h300, 1'b0, 1'b0, 1'b0, 12'h300, S_FLUSH, 1'b0, 1'b0);
    step("flush_ignores", 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h300, S_FLUSH, 1'b0, 1'b0);
    idle("resume_300", 12'h300, S_RUN, 1'b0, 1'b0);
    idle("run_301", 12'h301, S_RUN, 1'b0, 1'b0);
    idle("run_302", 12'h302, S_RUN, 1'b0, 1'b0);
    idle("run_303", 12'h303, S_RUN, 1'b0, 1'b0);
    step("ret_051", 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h051, S_RUN, 1'b1, 1'b0);

    // Overflow: calls at 1,3,5,7,9 push 2,4,6,8,10; oldest (2) lost
    redirect_to("to_001", 12'h001, 1'b1, 1'b0);
    step("call_1", 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'd2, S_RUN, 1'b0, 1'b0);
    idle("run_3", 12'd3, S_RUN, 1'b0, 1'b0);
    step("call_3", 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'd4, S_RUN, 1'b0, 1'b0);
    idle("run_5", 12'd5, S_RUN, 1'b0, 1'b0);
    step("call_5", 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'd6, S_RUN, 1'b0, 1'b0);
    idle("run_7", 12'd7, S_RUN, 1'b0, 1'b0);
    step("call_7_full", 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'd8, S_RUN, 1'b0, 1'b1);
    idle("run_9", 12'd9, S_RUN, 1'b0, 1'b1);
    step("call_9_wrap", 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'd10, S_RUN, 1'b0, 1'b1);
    step("ret_10", 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'd10, S_RUN, 1'b0, 1'b0);
    step("ret_8", 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'd8, S_RUN, 1'b0, 1'b0);
    step("ret_6", 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'd6, S_RUN, 1'b0, 1'b0);
    step("ret_4", 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'd4, S_RUN, 1'b1, 1'b0);
    step("ret_empty", 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'd5, S_RUN, 1'b1, 1'b0);

    // call+ret together: ret wins, call dropped
    step("call_5b", 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'd6, S_RUN, 1'b0, 1'b0);
    idle("run_7b", 12'd7, S_RUN, 1'b0, 1'b0);
    step("call_ret", 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'd6, S_RUN, 1'b1, 1'b0);
    step("ret_after_cr", 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'd7, S_RUN, 1'b1, 1'b0);

    // Redirect beats stall at 0xFFF; wrap; stall holds and masks call/ret
    redirect_to("to_fff", 12'hFFF, 1'b1, 1'b0);
    step("redir_stall", 1'b1, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 12'h123, S_FLUSH, 1'b1, 1'b0);
    idle("flush_123_b", 12'h123, S_FLUSH, 1'b1, 1'b0);
    idle("resume_123", 12'h123, S_RUN, 1'b1, 1'b0);
    redirect_to("to_fff2", 12'hFFF, 1'b1, 1'b0);
    idle("wrap_000", 12'h000, S_RUN, 1'b1, 1'b0);
    step("stall_call", 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, S_RUN, 1'b1, 1'b0);
    step("stall_ret", 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000, S_RUN, 1'b1, 1'b0);
    step("stall_plain", 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, S_RUN, 1'b1, 1'b0);
    idle("run_after_stall", 12'h001, S_RUN, 1'b1, 1'b0);

    // Halt at 7 is absorbing
    redirect_to("to_007", 12'h007, 1'b1, 1'b0);
    step("halt_7", 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h007, S_HALT, 1'b1, 1'b0);
    step("halt_redir", 1'b0, 1'b1, 12'h400, 1'b1, 1'b0, 1'b0, 12'h007, S_HALT, 1'b1, 1'b0);
    idle("halt_hold", 12'h007, S_HALT, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    expect_out("reset_in_halt", 12'h000, S_RUN, 1'b1, 1'b0);
    check_out();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Reset mid-FLUSH takes effect without a clock edge
    step("redir_080", 1'b0, 1'b1, 12'h080, 1'b0, 1'b0, 1'b0, 12'h080, S_FLUSH, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    expect_out("reset_in_flush", 12'h000, S_RUN, 1'b1, 1'b0);
    check_out();
    @(negedge clock);
    reset = 1'b0;
    idle("run_after_reset", 12'h001, S_RUN, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
